// File: rtl/requests_dispatcher_pkg.sv
// Register-map defines, FSM encodings and shared types for requests_dispatcher.
// These defines are the register-map constants shared with the other register blocks.
`ifndef CONF_REGS_DEFINES
`define CONF_REGS_DEFINES
`define __REG_ADDR_WIDTH    8
`define __REG_DATA_WIDTH    16
`define __RQST_START_IDX    0
`define __RQST_STOP_IDX     1
`define __RQST_TRIG_IDX     2
`define __RQST_RST_IDX      3
`define __RQST_CH_BASE_IDX  4
`define __RQST_FSM_IDLE     2'd0
`define __RQST_FSM_REQ      2'd1
`define __RQST_FSM_GAP      2'd2
`endif

package requests_dispatcher_pkg;

  localparam int unsigned RQST_START_IDX   = `__RQST_START_IDX;
  localparam int unsigned RQST_STOP_IDX    = `__RQST_STOP_IDX;
  localparam int unsigned RQST_TRIG_IDX    = `__RQST_TRIG_IDX;
  localparam int unsigned RQST_RST_IDX     = `__RQST_RST_IDX;
  localparam int unsigned RQST_CH_BASE_IDX = `__RQST_CH_BASE_IDX;

  typedef enum logic [1:0] {
    ST_IDLE = `__RQST_FSM_IDLE,
    ST_REQ  = `__RQST_FSM_REQ,
    ST_GAP  = `__RQST_FSM_GAP
  } rqst_state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/requests_dispatcher_if.sv
// Register write bus between the serial register interface and requests_dispatcher.
// si_rdy is a one-cycle write strobe with no backpressure: every strobe is a completed write.
interface requests_dispatcher_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] si_addr;
  logic [DW-1:0] si_data;
  logic          si_rdy;

  modport master (output si_addr, output si_data, output si_rdy);
  modport slave  (input  si_addr, input  si_data, input  si_rdy);
endinterface

// File: rtl/rqst_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted bit plus a valid flag.
module rqst_prio_enc #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/requests_dispatcher.sv
// Register command decoder and ascending-order channel-service sequencer.
// Optional ack timeout is built only when RQST_TIMEOUT_EN is defined.
module requests_dispatcher
  import requests_dispatcher_pkg::*;
#(
  parameter int unsigned             REG_ADDR_WIDTH = `__REG_ADDR_WIDTH,
  parameter int unsigned             REG_DATA_WIDTH = `__REG_DATA_WIDTH,
  parameter logic [REG_ADDR_WIDTH-1:0] MY_ADDR      = '0,
  parameter int unsigned             NUM_CH         = 2,
  parameter int unsigned             RESET_LEN      = 4,
  parameter int unsigned             TIMEOUT_CYCLES = 1024,
  localparam int unsigned            IDXW           = idx_width(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  requests_dispatcher_if.slave        bus,
  output logic                        start_o,
  output logic                        stop_o,
  output logic                        running_o,
  output logic                        rqst_trigger_status_o,
  output logic                        reset_o,
  // ch_req_o is held until ch_ack_i is sampled high in the same cycle; ack is ignored otherwise.
  output logic [NUM_CH-1:0]           ch_req_o,
  output logic [IDXW-1:0]             ch_idx_o,
  input  logic                        ch_ack_i,
  output logic [NUM_CH-1:0]           pending_o,
  output logic                        busy_o,
  output logic                        timeout_o,
  output rqst_state_e                 state_o
);

  localparam int unsigned RCW = $clog2(RESET_LEN + 1);

  if (REG_DATA_WIDTH < RQST_CH_BASE_IDX + NUM_CH) begin : g_bad_dw
    $error("REG_DATA_WIDTH too narrow for NUM_CH channel bits");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_nch
    $error("NUM_CH must be 1..8");
  end
  if (RESET_LEN < 1) begin : g_bad_rlen
    $error("RESET_LEN must be at least 1");
  end

  // Write decode
  logic              wr, wr_rst, wr_start, wr_stop, wr_trig;
  logic [NUM_CH-1:0] wr_ch;
  logic              unused_data;

  assign wr          = bus.si_rdy && (bus.si_addr == MY_ADDR);
  assign wr_rst      = wr && bus.si_data[RQST_RST_IDX];
  assign wr_ch       = (wr && !wr_rst) ? bus.si_data[RQST_CH_BASE_IDX +: NUM_CH] : '0;
  assign wr_stop     = wr && !wr_rst && (bus.si_data[RQST_STOP_IDX] || (wr_ch != '0));
  assign wr_start    = wr && !wr_rst && bus.si_data[RQST_START_IDX] && !wr_stop;
  assign wr_trig     = wr && !wr_rst && bus.si_data[RQST_TRIG_IDX];
  assign unused_data = ^bus.si_data;

  // Registers
  rqst_state_e       state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] pending_q, pending_d, clr_mask;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic              start_q, stop_q, trig_q, running_q, running_d;
  logic              tmo_fire;
  logic [IDXW-1:0]   enc_idx;
  logic              enc_valid;

  rqst_prio_enc #(.N(NUM_CH), .IW(IDXW)) u_prio_enc (
    .vec_i   (pending_q),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

`ifdef RQST_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           timeout_q;
  logic           tmo_expire;

  assign tmo_expire = (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
  // The counter restarts from zero on every entry into REQ.
  assign tmo_cnt_d  = (state_q == ST_REQ && state_d == ST_REQ) ? tmo_cnt_q + TCW'(1) : '0;
  assign timeout_o  = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= tmo_fire;
    end
  end
`else
  localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;
  logic tmo_expire;

  assign tmo_expire = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // Next-state and per-channel clear; an RST write overrides the whole sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_mask = '0;
    tmo_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_REQ;
          idx_d   = enc_idx;
        end
      end
      ST_REQ: begin
        if (ch_ack_i) begin
          clr_mask = NUM_CH'(1) << idx_q;
          state_d  = ST_GAP;
        end else if (tmo_expire) begin
          clr_mask = NUM_CH'(1) << idx_q;
          tmo_fire = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (wr_rst) begin
      state_d  = ST_IDLE;
      tmo_fire = 1'b0;
    end
  end

  // A write setting a bit on the same edge as its clear wins, so the channel stays queued.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | wr_ch;
    if (wr_rst) pending_d = '0;
  end

  always_comb begin
    running_d = running_q;
    if (wr_rst || wr_stop) running_d = 1'b0;
    else if (wr_start)     running_d = 1'b1;
  end

  // A fresh RST write reloads the pulse length even while reset_o is already high.
  always_comb begin
    rcnt_d = (rcnt_q != '0) ? rcnt_q - RCW'(1) : '0;
    if (wr_rst) rcnt_d = RCW'(RESET_LEN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      rcnt_q    <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      trig_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      rcnt_q    <= rcnt_d;
      start_q   <= wr_start;
      stop_q    <= wr_stop;
      trig_q    <= wr_trig;
      running_q <= running_d;
    end
  end

  assign start_o               = start_q;
  assign stop_o                = stop_q;
  assign rqst_trigger_status_o = trig_q;
  assign running_o             = running_q;
  assign reset_o               = (rcnt_q != '0);
  assign ch_req_o              = (state_q == ST_REQ) ? (NUM_CH'(1) << idx_q) : '0;
  assign ch_idx_o              = (state_q == ST_REQ) ? idx_q : '0;
  assign pending_o             = pending_q;
  assign busy_o                = (state_q != ST_IDLE) || (pending_q != '0);
  assign state_o               = state_q;

endmodule

// File: tb/tb_requests_dispatcher.sv
// Directed plus randomized bench for requests_dispatcher against a behavioural service model.
module tb_requests_dispatcher;
  import requests_dispatcher_pkg::*;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned NCH  = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned RLEN = 4;
  localparam int unsigned TMO  = 8;
  localparam logic [AW-1:0] ADDR = 8'h5A;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  requests_dispatcher_if #(.AW(AW), .DW(DW)) bus ();

  logic           start_o, stop_o, running_o, trig_o, reset_o, busy_o, timeout_o;
  logic [NCH-1:0] ch_req_o, pending_o;
  logic [IW-1:0]  ch_idx_o;
  logic           ack;
  rqst_state_e    state_o;

  requests_dispatcher #(
    .REG_ADDR_WIDTH (AW),
    .REG_DATA_WIDTH (DW),
    .MY_ADDR        (ADDR),
    .NUM_CH         (NCH),
    .RESET_LEN      (RLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus),
    .start_o               (start_o),
    .stop_o                (stop_o),
    .running_o             (running_o),
    .rqst_trigger_status_o (trig_o),
    .reset_o               (reset_o),
    .ch_req_o              (ch_req_o),
    .ch_idx_o              (ch_idx_o),
    .ch_ack_i              (ack),
    .pending_o             (pending_o),
    .busy_o                (busy_o),
    .timeout_o             (timeout_o),
    .state_o               (state_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: a set of waiting channels, the one being offered (-1 = none),
  // a cool-down before the next offer, and simple pulse/level outputs.
  bit m_pend[NCH];
  int m_cur      = -1;
  int m_hold     = 0;
  int m_age      = 0;
  int m_rst_left = 0;
  bit m_run, m_start, m_stop, m_trig, m_tmo;

  task automatic model_clear();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cur = -1; m_hold = 0; m_age = 0; m_rst_left = 0;
    m_run = 0; m_start = 0; m_stop = 0; m_trig = 0; m_tmo = 0;
  endtask

  task automatic model_edge();
    bit             acc;
    bit [DW-1:0]    d;
    bit [NCH-1:0]   chans;
    bit             done;
    if (!rst) begin
      model_clear();
      return;
    end
    acc = bus.si_rdy && (bus.si_addr == ADDR);
    d   = bus.si_data;
    m_start = 0; m_stop = 0; m_trig = 0; m_tmo = 0;
    if (m_rst_left > 0) m_rst_left--;
    if (acc && d[3]) begin
      m_rst_left = RLEN;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_cur = -1; m_hold = 0; m_age = 0; m_run = 0;
      return;
    end
    chans = '0;
    for (int k = 0; k < NCH; k++) chans[k] = acc && d[4 + k];
    m_stop  = acc && (d[1] || chans != '0);
    m_start = acc && d[0] && !m_stop;
    m_trig  = acc && d[2];
    if (m_stop) m_run = 0;
    else if (m_start) m_run = 1;
    if (m_cur >= 0) begin
      done = 0;
      if (ack) done = 1;
`ifdef RQST_TIMEOUT_EN
      else if (m_age == TMO - 1) begin
        done  = 1;
        m_tmo = 1;
      end
`endif
      if (done) begin
        m_pend[m_cur] = 1'b0;
        m_cur  = -1;
        m_hold = 1;
      end else begin
        m_age++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      for (int k = NCH - 1; k >= 0; k--) if (m_pend[k]) m_cur = k;
      m_age = 0;
    end
    for (int k = 0; k < NCH; k++) if (chans[k]) m_pend[k] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] one;
    logic [NCH-1:0] e_req, e_pend;
    logic [IW-1:0]  e_idx;
    bit             any_pend;
    one = 1;
    e_pend = '0;
    for (int k = 0; k < NCH; k++) e_pend[k] = m_pend[k];
    any_pend = (e_pend != '0);
    e_req = (m_cur >= 0) ? (one << m_cur) : '0;
    e_idx = (m_cur >= 0) ? IW'(m_cur) : '0;
    chk("start_o",   32'(start_o),   32'(m_start));
    chk("stop_o",    32'(stop_o),    32'(m_stop));
    chk("running_o", 32'(running_o), 32'(m_run));
    chk("trig_o",    32'(trig_o),    32'(m_trig));
    chk("reset_o",   32'(reset_o),   32'(m_rst_left > 0));
    chk("ch_req_o",  32'(ch_req_o),  32'(e_req));
    chk("ch_idx_o",  32'(ch_idx_o),  32'(e_idx));
    chk("pending_o", 32'(pending_o), 32'(e_pend));
    chk("busy_o",    32'(busy_o),    32'(m_cur >= 0 || m_hold > 0 || any_pend));
    chk("timeout_o", 32'(timeout_o), 32'(m_tmo));
  endtask

  // Driver tasks: one call = one clock edge, then outputs checked 1 time unit later.
  task automatic cyc(input logic rdy, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic ak);
    bus.si_rdy  = rdy;
    bus.si_addr = a;
    bus.si_data = d;
    ack         = ak;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cyc(1'b1, ADDR, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ADDR, '0, 1'b0);
  endtask

  task automatic ack_cyc();
    cyc(1'b0, ADDR, '0, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    model_clear();
    bus.si_rdy = 1'b0; bus.si_addr = '0; bus.si_data = '0; ack = 1'b0;

    // Reset held two cycles, then released.
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);

    // START, then START|STOP (STOP dominates), then writes that must be ignored.
    wr(16'h0001); idle(1);
    wr(16'h0003); idle(1);
    cyc(1'b1, ADDR ^ 8'h01, 16'h0001, 1'b0); idle(1);
    cyc(1'b0, ADDR, 16'h0001, 1'b0);
    wr(16'h0004); idle(1);
    wr(16'h0001); wr(16'hF000); idle(1);

    // CH2|CH0: CH0 served first, acked after 3 cycles, gap, then CH2.
    wr(16'h0050); idle(3); ack_cyc();
    idle(4); ack_cyc(); idle(3);

    // Rewrite CH0 on its own ack cycle: CH0 is offered again after the gap.
    wr(16'h0010); idle(2);
    cyc(1'b1, ADDR, 16'h0010, 1'b1);
    idle(3); ack_cyc(); idle(3);

    // RST during REQ, and RST reload while reset_o is high.
    wr(16'h0001); wr(16'h0020); idle(2);
    wr(16'h0008); idle(6);
    wr(16'h0008); idle(2); wr(16'h0008); idle(6);

    // No ack: timeout path with the macro, held request without it.
    wr(16'h0080); idle(12); ack_cyc(); idle(3);

    // Randomized traffic including back-to-back writes and occasional reset.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 149) != 0);
      ra  = ($urandom_range(0, 3) != 0) ? ADDR : AW'($urandom_range(0, 255));
      rd  = DW'($urandom);
      if ($urandom_range(0, 24) != 0) rd[3] = 1'b0;
      cyc(($urandom_range(0, 2) != 0), ra, rd, ($urandom_range(0, 2) == 0));
    end
    rst = 1'b1;
    for (int n = 0; n < 40; n++) cyc(1'b0, ADDR, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/requests_dispatcher.md
# requests_dispatcher

Parametrised request decoder and channel-service sequencer on the PC register bus. It decodes writes to its address into START/STOP/TRIG/RESET commands and keeps a sticky acquisition run state. It queues per-channel data requests for up to NUM_CH channels and hands them one at a time, in ascending index order, to the data sender over a req/ack handshake. It sits between the serial register interface and the acquisition core/data sender.

## Interface
- REG_ADDR_WIDTH, `__REG_ADDR_WIDTH`, register address width
- REG_DATA_WIDTH, `__REG_DATA_WIDTH`, register data width; must be ≥ 4+NUM_CH (elaboration error otherwise)
- MY_ADDR, 0, address this block responds to
- NUM_CH, 2, number of data channels, 1..8
- RESET_LEN, 4, reset_o pulse length in cycles, ≥1
- TIMEOUT_CYCLES, 1024, ack timeout; used only with RQST_TIMEOUT_EN
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- si_addr  in  REG_ADDR_WIDTH  register address
- si_data  in  REG_DATA_WIDTH  register data
- si_rdy  in  1  write strobe, one cycle per write
- start_o  out  1  one-cycle start pulse
- stop_o  out  1  one-cycle stop pulse
- running_o  out  1  sticky run state
- rqst_trigger_status_o  out  1  one-cycle trigger-status request pulse
- reset_o  out  1  soft-reset pulse, RESET_LEN cycles
- ch_req_o  out  NUM_CH  one-hot channel request to data sender
- ch_idx_o  out  clog2(NUM_CH) (min 1)  index of channel in ch_req_o
- ch_ack_i  in  1  data sender done with current channel
- pending_o  out  NUM_CH  queued channel requests
- busy_o  out  1  FSM not IDLE or pending_o ≠ 0
- timeout_o  out  1  one-cycle pulse on ack timeout (tied 0 without RQST_TIMEOUT_EN)

## Operation
- Write accepted when si_rdy=1 and si_addr=MY_ADDR; others ignored. Field bits: START `__RQST_START_IDX`, STOP `__RQST_STOP_IDX`, TRIG `__RQST_TRIG_IDX`, RST `__RQST_RST_IDX`, channel k at `__RQST_CH_BASE_IDX`+k. Unused upper bits ignored.
- stop_o pulses if STOP or any channel bit is set. A channel request always halts capture first.
- start_o pulses if START is set and STOP and all channel bits are clear. STOP dominates a simultaneous START.
- running_o: set by an effective start, cleared by stop_o or RST.
- Channel bits are OR-merged into pending. A duplicate request for an already pending channel is absorbed.
- FSM states:
  - IDLE: pending ≠ 0 → REQ, latching the lowest pending index k.
  - REQ: ch_req_o[k]=1 and ch_idx_o=k, held until ch_ack_i=1. Then clear pending[k] → GAP.
  - GAP: all ch_req_o low for one cycle → IDLE.
- ch_ack_i is ignored outside REG.
- A new write setting pending[k] in the same cycle the ack clears it leaves pending[k] set.
- RST bit: reset_o high for RESET_LEN cycles via down-counter; pending cleared; FSM → IDLE; running_o → 0. Other bits in the same write are ignored.
- An RST write while reset_o is active reloads the counter.

## Timing
- Reset (rst=0 at an edge): every output 0, FSM IDLE, counters 0. Effect is visible the cycle after that edge.
- Write at edge E0:
  - start_o / stop_o / rqst_trigger_status_o / reset_o rise after E0.
  - running_o and pending_o update after E0.
- From IDLE, ch_req_o rises after E1, exactly one cycle after stop_o.
- ch_ack_i sampled high at edge A: ch_req_o low after A. Next channel's ch_req_o rises after A+2 (GAP, IDLE).
- Back-to-back writes every cycle are accepted with no loss.
- rst=0 mid-handshake: ch_req_o low the next cycle, queue lost.

## Configuration
- RQST_TIMEOUT_EN defined:
  - A cycle counter runs in REQ.
  - If TIMEOUT_CYCLES elapse without ch_ack_i, pending[k] is dropped, timeout_o pulses one cycle, and the FSM goes → GAP.
  - An ack on the same edge as expiry counts as ack, with no timeout.
- Undefined: REQ waits indefinitely; timeout_o is constant 0; no counter is built.

## Structure
- Shared defines in `conf_regs_defines.v`:
  - bit indices `__RQST_START_IDX`, `__RQST_STOP_IDX`, `__RQST_TRIG_IDX`, `__RQST_RST_IDX`, `__RQST_CH_BASE_IDX`
  - FSM state encodings
  - `__REG_ADDR_WIDTH` / `__REG_DATA_WIDTH`
- One sub-module, rqst_prio_enc: combinational lowest-set-bit priority encoder over NUM_CH bits, giving index and valid.

## Test plan
- rst=0 two cycles, then release → all outputs 0, busy_o=0.
- Write START at MY_ADDR → start_o one cycle, running_o=1. Write START|STOP → only stop_o, running_o=0.
- NUM_CH=4, write CH2|CH0 → stop_o, then ch_req_o=0001 with idx 0. Ack after 3 cycles → one gap cycle, then ch_req_o=0100, idx 2. pending_o goes 0101→0100→0000.
- While serving CH0, rewrite CH0 on the ack cycle → CH0 is served again after GAP.
- Write RST during REQ with RESET_LEN=4 → reset_o high exactly 4 cycles, ch_req_o low next cycle, pending_o=0.
- With RQST_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → timeout_o pulses once after 8 REQ cycles and the pending bit clears. Without the macro, ch_req_o is held indefinitely.
